// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a valid/ready handshake, 2-entry skid buffer and NOP-inserting flush.
// Optional saturating stall/flush counters are enabled by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] NOP_VAL = 32'h0000_0013,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_VAL);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_fire;
  logic              w_out_fire;

  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign occupancy  = r_state;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = NOP;
      w_skid_nxt  = NOP;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = NOP;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = NOP;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = NOP;
          w_skid_nxt  = NOP;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: payload registers are reset too, because the main register is visible as out_data.
      r_state <= ST_EMPTY;
      r_main  <= NOP;
      r_skid  <= NOP;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall;

  assign w_stall = out_valid & ~out_ready;

  // Counters saturate at all-ones and clear only on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised scoreboard bench for pipe_stage_buf: an abstract FIFO model predicts every output,
// and a separate monitor compares the DUT against it. A second instance uses 2-bit counters.
module tb_pipe_stage_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 16;
  localparam int          CWS = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid;
  logic [31:0]   out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic           s_in_ready, s_out_valid;
  logic [31:0]    s_out_data;
  logic [1:0]     s_occupancy;
  logic [CWS-1:0] s_stall_cnt, s_flush_cnt;

  pipe_stage_buf dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_buf #(.CNT_W(CWS)) dut_sat (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int cnt, input int width);
    int max;
    max = (1 << width) - 1;
`ifdef PIPE_STAGE_BUF_PERF_EN
    return (cnt > max) ? 64'(max) : 64'(cnt);
`else
    return 64'd0;
`endif
  endfunction

  // Reference model: the stage is a FIFO of depth 2; flush empties it.
  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];
  int          m_stall = 0;
  int          m_flush = 0;
  int          e_occ;
  logic [31:0] e_data;
  int          e_stall, e_flush;

  always @(negedge CLK) begin
    bit of, inf;
    if (!RST) begin
      m_q.delete();
      exp_q.delete();
      m_stall = 0;
      m_flush = 0;
    end
    e_occ   = m_q.size();
    e_data  = (m_q.size() > 0) ? m_q[0] : NOP;
    e_stall = m_stall;
    e_flush = m_flush;
    if (RST) begin
      of  = (m_q.size() > 0) && out_ready;
      inf = in_valid && (m_q.size() < 2);
      if ((m_q.size() > 0) && !out_ready) m_stall++;
      if (flush) m_flush++;
      if (of) exp_q.push_back(m_q[0]);
      if (flush) begin
        m_q.delete();
      end else begin
        if (of) void'(m_q.pop_front());
        if (inf) m_q.push_back(in_data);
      end
    end
  end

  // Monitor: compares DUT outputs with the model snapshot and pops the scoreboard on out_fire.
  always begin
    @(negedge CLK);
    #1;
    check("occupancy", 64'(occupancy), 64'(e_occ));
    check("out_valid", 64'(out_valid), 64'(e_occ != 0));
    check("in_ready", 64'(in_ready), 64'(e_occ != 2));
    check("out_data", 64'(out_data), 64'(e_data));
    check("stall_cnt", 64'(stall_cnt), exp_cnt(e_stall, CW));
    check("flush_cnt", 64'(flush_cnt), exp_cnt(e_flush, CW));
    check("sat_occupancy", 64'(s_occupancy), 64'(e_occ));
    check("sat_out_data", 64'(s_out_data), 64'(e_data));
    check("sat_stall_cnt", 64'(s_stall_cnt), exp_cnt(e_stall, CWS));
    check("sat_flush_cnt", 64'(s_flush_cnt), exp_cnt(e_flush, CWS));
    if (RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else check("sb_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  // Upstream source: holds a payload until the stage accepts it.
  logic [31:0] src_q[$];

  task automatic cycle(input logic fl, input logic ordy, input logic iv);
    flush     = fl;
    out_ready = ordy;
    in_valid  = iv && (src_q.size() > 0);
    in_data   = in_valid ? src_q[0] : $urandom;
    @(negedge CLK);
    if (in_valid && in_ready) void'(src_q.pop_front());
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset held with in_valid high; the monitor checks reset values every cycle.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    cycle(0, 1, 0);
    cycle(0, 1, 0);

    for (int i = 0; i < 8; i++) src_q.push_back(32'hA0 + i);
    repeat (10) cycle(0, 1, 1);

    for (int i = 0; i < 3; i++) src_q.push_back(32'hB0 + i);
    repeat (4) cycle(0, 0, 1);
    check("bp_occupancy", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_held_upstream", 64'(src_q.size()), 64'd1);
    repeat (5) cycle(0, 1, 1);

    src_q.push_back(32'hC0);
    src_q.push_back(32'hC1);
    repeat (2) cycle(0, 0, 1);
    src_q.push_back(32'hC2);
    cycle(1, 0, 1);
    check("flush_occupancy", 64'(occupancy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data", 64'(out_data), 64'(NOP));
    src_q.delete();
    repeat (2) cycle(0, 1, 0);

    src_q.push_back(32'hD0);
    cycle(0, 0, 1);
    src_q.push_back(32'hD1);
    cycle(1, 1, 1);
    src_q.push_back(32'hE0);
    src_q.push_back(32'hE1);
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    check("flush_held_in_ready", 64'(in_ready), 64'd1);
    repeat (2) cycle(0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 4) src_q.push_back($urandom);
      cycle(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset while two entries are held, between clock edges.
    src_q.delete();
    cycle(1, 0, 0);
    src_q.push_back(32'hF0);
    src_q.push_back(32'hF1);
    repeat (2) cycle(0, 0, 1);
    #2;
    RST = 1'b0;
    #1;
    check("arst_occupancy", 64'(occupancy), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'(NOP));
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("arst_flush_cnt", 64'(flush_cnt), 64'd0);
    src_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cycle(0, 1, 0);

    // Counter scenario: 5 stall cycles then 2 flush cycles.
    src_q.push_back(32'h77);
    cycle(0, 0, 1);
    repeat (5) cycle(0, 0, 0);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    check("perf_stall_cnt", 64'(stall_cnt), 64'd5);
    check("perf_flush_cnt", 64'(flush_cnt), 64'd2);
    check("perf_sat_stall_cnt", 64'(s_stall_cnt), 64'd3);
    check("perf_sat_flush_cnt", 64'(s_flush_cnt), 64'd2);
`else
    check("perf_stall_cnt", 64'(stall_cnt), 64'd0);
    check("perf_flush_cnt", 64'(flush_cnt), 64'd0);
    check("perf_sat_stall_cnt", 64'(s_stall_cnt), 64'd0);
    check("perf_sat_flush_cnt", 64'(s_flush_cnt), 64'd0);
`endif

    repeat (3) cycle(0, 1, 0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register replacing the fixed fetch/decode/exec stage latches.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure stalls the upstream stage without combinational ready paths.
- Adds a synchronous flush that inserts a NOP bubble on control hazards.
- Instantiated once per stage boundary; the payload is an opaque packed vector.

Parameters:
- DATA_W, 32, payload width in bits
- NOP_VAL, 32'h0000_0013 (zero-extended/truncated to DATA_W), payload presented when empty, flushed or in reset
- CNT_W, 16, width of performance counters (used only with the optional feature)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-low
- flush  in  1  synchronous flush (control hazard); highest priority
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept; decoded from registered state only
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  payload valid to downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to downstream
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready
- flush_cnt  out  CNT_W  cycles with flush high

Behaviour:
- Reset (RST=0, asynchronous):
  - state EMPTY; main and skid registers = NOP_VAL.
  - Outputs: out_valid=0, out_data=NOP_VAL, in_ready=1, occupancy=0, counters=0.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States are EMPTY, ONE (main valid) and TWO (main and skid valid). occupancy = 0/1/2 respectively.
- Outputs per state:
  - in_ready = (state != TWO); no combinational dependence on out_ready.
  - out_valid = (state != EMPTY).
  - out_data = main register, which holds NOP_VAL while EMPTY.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire & !out_fire -> TWO, skid<=in_data.
    - !in_fire & out_fire -> EMPTY, main<=NOP_VAL.
    - Otherwise hold.
  - TWO: out_fire -> ONE, main<=skid, skid<=NOP_VAL. Otherwise hold. in_ready=0, so no input is accepted.
- Latency: 1 cycle from in_fire to out_valid when downstream is ready. Throughput is 1 per cycle at steady state.
- Ordering is strict FIFO; no payload is duplicated or dropped except by flush.
- Flush (flush=1 at an edge):
  - Next state EMPTY; main and skid <= NOP_VAL regardless of in_valid, out_ready or state.
  - A payload presented with in_fire in the same cycle is discarded.
  - An out_fire in the same cycle counts as consumed by downstream; the buffer does not replay it.
  - Flush held multiple cycles keeps the stage EMPTY with in_ready=1.
- Payload stability: out_data is stable while out_valid & !out_ready.
- Reset mid-operation: immediate return to reset values; any held entries are lost.

Optional Feature:
- Macro: PIPE_STAGE_BUF_PERF_EN.
- When defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle with flush=1.
  - Both counters saturate at all-ones (no wrap) and clear only on reset.
- When undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist. Ports remain present.

Test Plan:
- Reset: RST=0 for 3 cycles, in_valid=1 -> out_valid=0, out_data=32'h13, in_ready=1, occupancy=0. Release RST -> still EMPTY until first edge with in_valid.
- Streaming: out_ready=1, push 0xA0..0xA7 back-to-back -> out_data sequence 0xA0..0xA7, each 1 cycle after accept; occupancy stays 1; in_ready stays 1.
- Back-pressure: hold out_ready=0 and push 0xB0, 0xB1, 0xB2 -> 0xB0 and 0xB1 accepted, occupancy=2, in_ready=0, 0xB2 held upstream. Raise out_ready -> outputs 0xB0, 0xB1, 0xB2 in order, none lost.
- Flush in TWO: state TWO holding 0xC0/0xC1, flush=1 with in_valid=1 and in_data=0xC2 -> next cycle occupancy=0, out_valid=0, out_data=32'h13. 0xC2 never appears on the output.
- Async reset mid-stall: occupancy=2, drop RST between clock edges -> outputs immediately return to reset values without a clock edge.
- PERF (macro defined): 5 stall cycles plus 2 flush cycles -> stall_cnt=5, flush_cnt=2. With CNT_W=2 and 6 stall cycles -> stall_cnt=3 (saturated). Macro undefined -> both counters read 0 throughout.
